core_mem_responder: RTL and testbench

- Memory-side responder for the core's instruction-fetch (rom_*) and data (ram_*) ports.
- Holds an instruction array and a data array, both word-organised.
- Serves combinational reads and clocked writes.
- Contains a boot-load FSM that streams a program into the instruction array over a valid/ready port while holding the core in reset, then releases it.
- Sits between the top level and the core; the core's rst_n is driven from core_rst_n.

---
 rtl/core_mem_responder.sv | 171 +++++++++++++++++
 tb/tb_core_mem_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_responder.sv
// Memory-side responder: instruction and data word arrays for the core, plus a
// boot loader that streams a program into the instruction array before releasing core reset.
module core_mem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int BUS_WIDTH  = 32,
    parameter int IMEM_BITS  = 10,
    parameter int DMEM_BITS  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BUS_WIDTH-1:0]  rom_address,
    output logic [DATA_WIDTH-1:0] rom_rdata,
    input  logic [BUS_WIDTH-1:0]  ram_address,
    input  logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_wdata,
    output logic [DATA_WIDTH-1:0] ram_rdata,
    input  logic                  boot_valid,
    output logic                  boot_ready,
    input  logic [DATA_WIDTH-1:0] boot_data,
    input  logic                  boot_last,
    input  logic                  boot_skip,
    output logic                  core_rst_n,
    output logic [IMEM_BITS:0]    boot_count,
    output logic                  boot_overflow,
    output logic                  addr_err,
    output logic [BUS_WIDTH-1:0]  addr_err_addr
);

    localparam int IMEM_DEPTH = 2 ** IMEM_BITS;
    localparam int DMEM_DEPTH = 2 ** DMEM_BITS;
    localparam logic [DATA_WIDTH-1:0] NOP_WORD = DATA_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t                 state_r;
    logic [IMEM_BITS-1:0]   load_ptr_r;
    logic [IMEM_BITS:0]     boot_count_r;
    logic                   boot_ready_r;
    logic                   core_rst_n_r;
    logic                   boot_overflow_r;
    logic                   addr_err_r;
    logic [BUS_WIDTH-1:0]   addr_err_addr_r;

    logic [DATA_WIDTH-1:0]  imem_r [IMEM_DEPTH];
    logic [DATA_WIDTH-1:0]  dmem_r [DMEM_DEPTH];

    logic [IMEM_BITS-1:0]           rom_idx_s;
    logic [BUS_WIDTH-IMEM_BITS-3:0] rom_hi_s;
    logic                           rom_in_range_s;
    logic [DMEM_BITS-1:0]           ram_idx_s;
    logic [BUS_WIDTH-DMEM_BITS-3:0] ram_hi_s;
    logic                           ram_in_range_s;
    logic                           boot_accept_s;
    logic                           last_slot_s;
    logic                           dmem_we_s;
    logic                           ram_err_s;
    logic                           unused_addr_bits_s;

    // Byte addresses map to word indices; any set bit above the index is out of range.
    assign rom_idx_s      = rom_address[IMEM_BITS+1:2];
    assign rom_hi_s       = rom_address[BUS_WIDTH-1:IMEM_BITS+2];
    assign rom_in_range_s = ~|rom_hi_s;
    assign ram_idx_s      = ram_address[DMEM_BITS+1:2];
    assign ram_hi_s       = ram_address[BUS_WIDTH-1:DMEM_BITS+2];
    assign ram_in_range_s = ~|ram_hi_s;
    assign unused_addr_bits_s = ^{rom_address[1:0], ram_address[1:0]};

    assign boot_accept_s = boot_valid & boot_ready_r & (state_r == ST_LOAD);
    assign last_slot_s   = &load_ptr_r;
    assign dmem_we_s     = (state_r == ST_RUN) & ram_we & ram_in_range_s;
    assign ram_err_s     = (state_r == ST_RUN) & ~ram_in_range_s;

    // Combinational read ports; unmapped fetches see a NOP, unmapped loads see zero.
    always_comb begin
        rom_rdata = NOP_WORD;
        ram_rdata = {DATA_WIDTH{1'b0}};
        if (rom_in_range_s) begin
            rom_rdata = imem_r[rom_idx_s];
        end else begin
            rom_rdata = NOP_WORD;
        end
        if (ram_in_range_s) begin
            ram_rdata = dmem_r[ram_idx_s];
        end else begin
            ram_rdata = {DATA_WIDTH{1'b0}};
        end
    end

    // Boot FSM with registered handshake, core reset and sticky error status.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            load_ptr_r      <= {IMEM_BITS{1'b0}};
            boot_count_r    <= {(IMEM_BITS+1){1'b0}};
            boot_ready_r    <= 1'b0;
            core_rst_n_r    <= 1'b0;
            boot_overflow_r <= 1'b0;
            addr_err_r      <= 1'b0;
            addr_err_addr_r <= {BUS_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    core_rst_n_r <= 1'b0;
                    if (boot_skip) begin
                        state_r      <= ST_RUN;
                        boot_ready_r <= 1'b0;
                    end else if (boot_valid) begin
                        state_r      <= ST_LOAD;
                        boot_ready_r <= 1'b1;
                    end else begin
                        boot_ready_r <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    core_rst_n_r <= 1'b0;
                    if (boot_accept_s) begin
                        load_ptr_r   <= load_ptr_r + IMEM_BITS'(1'b1);
                        boot_count_r <= boot_count_r + (IMEM_BITS+1)'(1'b1);
                        if (boot_last || last_slot_s) begin
                            state_r      <= ST_RUN;
                            boot_ready_r <= 1'b0;
                        end
                        // Filling the final slot without an end marker means the stream was too long.
                        if (last_slot_s && !boot_last) begin
                            boot_overflow_r <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    core_rst_n_r <= 1'b1;
                    boot_ready_r <= 1'b0;
                    if (ram_err_s && !addr_err_r) begin
                        addr_err_r      <= 1'b1;
                        addr_err_addr_r <= ram_address;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    core_rst_n_r <= 1'b0;
                    boot_ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Instruction array: written only by accepted boot words, contents survive reset.
    always_ff @(posedge clk) begin
        if (rst_n && boot_accept_s) begin
            imem_r[load_ptr_r] <= boot_data;
        end
    end

    // Data array: core writes only while running and only to mapped words.
    always_ff @(posedge clk) begin
        if (rst_n && dmem_we_s) begin
            dmem_r[ram_idx_s] <= ram_wdata;
        end
    end

    assign boot_ready    = boot_ready_r;
    assign core_rst_n    = core_rst_n_r;
    assign boot_count    = boot_count_r;
    assign boot_overflow = boot_overflow_r;
    assign addr_err      = addr_err_r;
    assign addr_err_addr = addr_err_addr_r;

endmodule

// File: tb/tb_core_mem_responder.sv
// Directed bench for core_mem_responder: boot loading, backpressure, overflow,
// data read/write ordering, out-of-range handling and reset from RUN.
module tb_core_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] rom_address, rom_rdata, ram_address, ram_wdata, ram_rdata;
    logic        ram_we, boot_valid, boot_ready, boot_last, boot_skip;
    logic [31:0] boot_data, addr_err_addr;
    logic        core_rst_n, boot_overflow, addr_err;
    logic [10:0] boot_count;

    logic [31:0] s_rom_address, s_rom_rdata, s_ram_address, s_ram_wdata, s_ram_rdata;
    logic        s_ram_we, s_boot_valid, s_boot_ready, s_boot_last, s_boot_skip;
    logic [31:0] s_boot_data, s_addr_err_addr;
    logic        s_core_rst_n, s_boot_overflow, s_addr_err;
    logic [2:0]  s_boot_count;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    core_mem_responder dut (
        .clk(clk), .rst_n(rst_n),
        .rom_address(rom_address), .rom_rdata(rom_rdata),
        .ram_address(ram_address), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .boot_valid(boot_valid), .boot_ready(boot_ready), .boot_data(boot_data),
        .boot_last(boot_last), .boot_skip(boot_skip),
        .core_rst_n(core_rst_n), .boot_count(boot_count), .boot_overflow(boot_overflow),
        .addr_err(addr_err), .addr_err_addr(addr_err_addr)
    );

    core_mem_responder #(.IMEM_BITS(2)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .rom_address(s_rom_address), .rom_rdata(s_rom_rdata),
        .ram_address(s_ram_address), .ram_we(s_ram_we), .ram_wdata(s_ram_wdata), .ram_rdata(s_ram_rdata),
        .boot_valid(s_boot_valid), .boot_ready(s_boot_ready), .boot_data(s_boot_data),
        .boot_last(s_boot_last), .boot_skip(s_boot_skip),
        .core_rst_n(s_core_rst_n), .boot_count(s_boot_count), .boot_overflow(s_boot_overflow),
        .addr_err(s_addr_err), .addr_err_addr(s_addr_err_addr)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rom_address = 32'h0; ram_address = 32'h0; ram_we = 1'b0; ram_wdata = 32'h0;
        boot_valid = 1'b0; boot_data = 32'h0; boot_last = 1'b0; boot_skip = 1'b0;
        s_rom_address = 32'h0; s_ram_address = 32'h0; s_ram_we = 1'b0; s_ram_wdata = 32'h0;
        s_boot_valid = 1'b0; s_boot_data = 32'h0; s_boot_last = 1'b0; s_boot_skip = 1'b0;

        // Reset held for two edges
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(boot_ready), 32'h0);
        check("rst_core_rst_n", 32'(core_rst_n), 32'h0);
        check("rst_count", 32'(boot_count), 32'h0);
        check("rst_overflow", 32'(boot_overflow), 32'h0);
        check("rst_addr_err", 32'(addr_err), 32'h0);
        check("rst_addr_err_addr", addr_err_addr, 32'h0);
        rst_n = 1'b1;

        // Three-word boot with valid held
        boot_valid = 1'b1; boot_data = 32'h0050_0093; boot_last = 1'b0;
        check("t1_ready_idle", 32'(boot_ready), 32'h0);
        @(negedge clk);
        check("t1_ready_1", 32'(boot_ready), 32'h1);
        check("t1_count_0", 32'(boot_count), 32'h0);
        @(negedge clk);
        check("t1_ready_2", 32'(boot_ready), 32'h1);
        check("t1_count_1", 32'(boot_count), 32'h1);
        boot_data = 32'h0030_0113;
        @(negedge clk);
        check("t1_ready_3", 32'(boot_ready), 32'h1);
        check("t1_count_2", 32'(boot_count), 32'h2);
        boot_data = 32'h0020_81B3; boot_last = 1'b1;
        @(negedge clk);
        check("t1_ready_done", 32'(boot_ready), 32'h0);
        check("t1_count_3", 32'(boot_count), 32'h3);
        check("t1_core_rst_still_low", 32'(core_rst_n), 32'h0);
        boot_valid = 1'b0; boot_last = 1'b0;
        @(negedge clk);
        check("t1_core_rst_high", 32'(core_rst_n), 32'h1);
        rom_address = 32'h8; #1;
        check("t1_rom_8", rom_rdata, 32'h0020_81B3);
        rom_address = 32'h0; #1;
        check("t1_rom_0", rom_rdata, 32'h0050_0093);
        rom_address = 32'h4; #1;
        check("t1_rom_4", rom_rdata, 32'h0030_0113);

        // Reload with gaps between valid words
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t2_core_rst_n_reset", 32'(core_rst_n), 32'h0);
        rst_n = 1'b1;
        boot_valid = 1'b1; boot_data = 32'hA000_0001;
        @(negedge clk);
        @(negedge clk);
        check("t2_count_after_g0", 32'(boot_count), 32'h1);
        boot_valid = 1'b0; boot_data = 32'hFFFF_FFFF;
        @(negedge clk);
        check("t2_count_gap1", 32'(boot_count), 32'h1);
        check("t2_ready_gap1", 32'(boot_ready), 32'h1);
        boot_valid = 1'b1; boot_data = 32'hA000_0002;
        @(negedge clk);
        check("t2_count_after_g1", 32'(boot_count), 32'h2);
        boot_valid = 1'b0; boot_data = 32'hEEEE_EEEE;
        @(negedge clk);
        check("t2_count_gap2", 32'(boot_count), 32'h2);
        boot_valid = 1'b1; boot_data = 32'hA000_0003; boot_last = 1'b1;
        @(negedge clk);
        check("t2_count_after_g2", 32'(boot_count), 32'h3);
        check("t2_ready_done", 32'(boot_ready), 32'h0);
        boot_valid = 1'b0; boot_last = 1'b0; boot_data = 32'h0;
        @(negedge clk);
        check("t2_core_rst_high", 32'(core_rst_n), 32'h1);
        rom_address = 32'h0; #1;
        check("t2_rom_0", rom_rdata, 32'hA000_0001);
        rom_address = 32'h4; #1;
        check("t2_rom_4", rom_rdata, 32'hA000_0002);
        rom_address = 32'h8; #1;
        check("t2_rom_8", rom_rdata, 32'hA000_0003);

        // Data write/read ordering in RUN
        ram_address = 32'h10; ram_we = 1'b1; ram_wdata = 32'h1111_1111;
        @(negedge clk);
        ram_wdata = 32'hDEAD_BEEF; #1;
        check("t3_same_cycle_old", ram_rdata, 32'h1111_1111);
        @(negedge clk);
        ram_we = 1'b0; #1;
        check("t3_read_10", ram_rdata, 32'hDEAD_BEEF);
        ram_address = 32'h13; #1;
        check("t3_read_13", ram_rdata, 32'hDEAD_BEEF);
        ram_address = 32'h0; ram_we = 1'b1; ram_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        ram_address = 32'h20; ram_wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        ram_we = 1'b0; #1;
        check("t3_read_20", ram_rdata, 32'hA5A5_A5A5);
        ram_address = 32'h0; #1;
        check("t3_read_0", ram_rdata, 32'hCAFE_F00D);
        check("t3_no_addr_err", 32'(addr_err), 32'h0);

        // Out-of-range data accesses
        ram_address = 32'h1000; ram_we = 1'b1; ram_wdata = 32'hBAD0_BAD0; #1;
        check("t4_oor_read_zero", ram_rdata, 32'h0);
        @(negedge clk);
        check("t4_addr_err", 32'(addr_err), 32'h1);
        check("t4_addr_err_addr", addr_err_addr, 32'h0000_1000);
        ram_we = 1'b0; ram_address = 32'h2000; #1;
        check("t4_read_2000", ram_rdata, 32'h0);
        @(negedge clk);
        check("t4_addr_err_addr_kept", addr_err_addr, 32'h0000_1000);
        ram_address = 32'h0; #1;
        check("t4_write_dropped", ram_rdata, 32'hCAFE_F00D);
        rom_address = 32'h1000; #1;
        check("t4_rom_nop", rom_rdata, 32'h0000_0013);

        // Overflow on a 4-word instruction array
        s_boot_valid = 1'b1; s_boot_data = 32'hB000_0000;
        @(negedge clk);
        check("t5_ready", 32'(s_boot_ready), 32'h1);
        for (int i = 0; i < 4; i++) begin
            s_boot_data = 32'hB000_0000 + 32'(i);
            check("t5_count_before", 32'(s_boot_count), 32'(i));
            check("t5_no_overflow_yet", 32'(s_boot_overflow), 32'h0);
            @(negedge clk);
        end
        check("t5_overflow", 32'(s_boot_overflow), 32'h1);
        check("t5_count_4", 32'(s_boot_count), 32'h4);
        check("t5_ready_dropped", 32'(s_boot_ready), 32'h0);
        s_boot_data = 32'hB000_0004;
        @(negedge clk);
        check("t5_core_rst_high", 32'(s_core_rst_n), 32'h1);
        s_boot_data = 32'hB000_0005;
        @(negedge clk);
        check("t5_count_still_4", 32'(s_boot_count), 32'h4);
        s_boot_valid = 1'b0;
        s_rom_address = 32'h0; #1;
        check("t5_rom_0_unchanged", s_rom_rdata, 32'hB000_0000);
        s_rom_address = 32'hC; #1;
        check("t5_rom_c", s_rom_rdata, 32'hB000_0003);
        s_rom_address = 32'h10; #1;
        check("t5_rom_oor_nop", s_rom_rdata, 32'h0000_0013);

        // Reset from RUN, ignored write in IDLE, then skip with valid also high
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_core_rst_n", 32'(core_rst_n), 32'h0);
        check("t6_count", 32'(boot_count), 32'h0);
        check("t6_addr_err", 32'(addr_err), 32'h0);
        check("t6_addr_err_addr", addr_err_addr, 32'h0);
        check("t6_small_overflow", 32'(s_boot_overflow), 32'h0);
        rst_n = 1'b1;
        ram_address = 32'h20; ram_we = 1'b1; ram_wdata = 32'h5A5A_5A5A;
        @(negedge clk);
        ram_we = 1'b0;
        check("t6_idle_core_rst_n", 32'(core_rst_n), 32'h0);
        boot_skip = 1'b1; boot_valid = 1'b1;
        @(negedge clk);
        boot_skip = 1'b0; boot_valid = 1'b0;
        check("t6_skip_ready_low", 32'(boot_ready), 32'h0);
        check("t6_skip_core_rst_low", 32'(core_rst_n), 32'h0);
        @(negedge clk);
        check("t6_skip_core_rst_high", 32'(core_rst_n), 32'h1);
        check("t6_skip_count", 32'(boot_count), 32'h0);
        #1;
        check("t6_idle_write_ignored", ram_rdata, 32'hA5A5_A5A5);
        ram_address = 32'h10; #1;
        check("t6_dmem_kept", ram_rdata, 32'hDEAD_BEEF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
